ntt_host_port: RTL and testbench
================================

// Module: ntt_host_port
// PURPOSE
// - Host-side initiator for the NTT core's memory and start/done interface.
// - Packs a coefficient stream into SIZE-lane rows and writes them via mem_write. Pulses start with mod_idx and waits for done.
// - Then reads rows back via mem_read and serialises them to an output stream. Sits between the system bus/DMA and the ntt core.
// PARAMETERS
// - WIDTH           32   coefficient width
// - SIZE            257  lanes (memory banks) per row
// - ROWS            256  max rows per job; addresses 0..ROWS-1 (8-bit per bank)
// - MEM_RD_LATENCY  2    cycles from ntt_mem_read/addr to valid ntt_dout
// - TIMEOUT_CYCLES  65535 compute watchdog limit (used only with NTT_HOST_TIMEOUT_EN)
// PORTS
// - clk            in   1            single clock
// - reset_n        in   1            asynchronous, active-low reset
// - cmd_valid      in   1            job request
// - cmd_ready      out  1            high only in IDLE
// - cmd_mod_idx    in   6            modulus index, legal 0..39
// - cmd_rows       in   9            rows in job, legal 1..ROWS
// - s_valid/s_ready in/out 1         input coefficient handshake
// - s_data         in   WIDTH        input coefficient
// - m_valid/m_ready out/in 1         output coefficient handshake
// - m_data         out  WIDTH        output coefficient
// - ntt_start      out  1            one-cycle start pulse to core
// - ntt_mod_idx    out  6            registered copy of cmd_mod_idx
// - ntt_mem_write  out  1            row write strobe
// - ntt_mem_read   out  1            row read strobe
// - ntt_mem_addr   out  8*SIZE       per-bank address; all banks carry the same row index
// - ntt_din        out  WIDTH*SIZE   packed row; lane k at [k*WIDTH+:WIDTH]
// - ntt_dout       in   WIDTH*SIZE   row read data
// - ntt_done       in   1            core completion
// - busy           out  1            not IDLE
// - err            out  1            sticky error; cleared on next accepted cmd
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 except cmd_ready=1; counters, row buffer and ntt_mod_idx are cleared.
// - FSM IDLE->LOAD->START->COMPUTE->UNLOAD->IDLE.
//   - IDLE: cmd_valid is accepted in the same cycle.
//   - Illegal mod_idx (>39) or rows==0 or rows>ROWS: set err, stay IDLE, no core activity.
// - LOAD:
//   - s_ready=1. Each accepted beat fills lane cnt (0..SIZE-1).
//   - After lane SIZE-1: ntt_mem_write=1 for exactly 1 cycle, with ntt_din=row and addr=row_idx. s_ready=0 during that cycle.
//   - After the last row, go to START.
// - START: ntt_start=1 for 1 cycle; ntt_mod_idx is stable from the previous cycle through COMPUTE.
// - COMPUTE: wait for ntt_done rising (0->1, edge-detected). ntt_mem_* held 0.
// - UNLOAD, per row:
//   - Pulse ntt_mem_read with addr=row.
//   - Capture ntt_dout exactly MEM_RD_LATENCY cycles later.
//   - Emit lanes 0..SIZE-1 on m_*. m_data/m_valid are stable while m_valid&&!m_ready.
//   - The next row read is issued only after the last lane handshakes.
//   - After the last row, go to IDLE.
// - Mutual exclusion: ntt_mem_read and ntt_mem_write are never both 1. ntt_mem_addr=0 when neither is asserted.
// - Latency: write strobe 1 cycle after the SIZE-th accepted beat. First m_valid at MEM_RD_LATENCY+1 cycles after the read strobe.
// - ntt_done seen outside COMPUTE is ignored. cmd_valid outside IDLE is ignored (cmd_ready=0).
// - Asynchronous reset mid-job aborts immediately. Partial rows are discarded and no further core strobes are issued.
// - Row and lane counters wrap to 0 only on the state transition, never mid-job.
// CONFIGURATION
// - NTT_HOST_TIMEOUT_EN defined:
//   - Adds a 16-bit watchdog in COMPUTE.
//   - When the count reaches TIMEOUT_CYCLES without done: err=1, go to IDLE, no UNLOAD.
// - NTT_HOST_TIMEOUT_EN undefined: COMPUTE waits indefinitely; err is set only by illegal commands.
// STRUCTURE
// - Shared package ntt_pkg holds:
//   - FSM state encoding;
//   - NUM_MODULI=40;
//   - MEM_DELAY and addr width 8;
//   - lane-index width $clog2(SIZE).
// - One sub-module, ntt_row_buffer: SIZE x WIDTH register row.
//   - Supports lane-indexed write, full-row parallel load/read and lane-indexed read.
//   - Shared by LOAD packing and UNLOAD serialisation, since they never overlap.
// TESTING
// - Single row: cmd mod_idx=0, rows=1; stream 0..256.
//   - Required: one write with lane k = k and addr all 0; one start pulse.
//   - Model done after 50 cycles; output 257 beats equal to the model dout.
// - Full job: rows=256 with m_ready toggling 1010.
//   - Required: 256 writes at addr 0..255, 256 reads in order, no beat lost or duplicated, m_data held under backpressure.
// - Illegal command: mod_idx=40 or rows=0.
//   - Required: err=1, busy=0, no ntt_start/mem strobes; a next legal cmd clears err.
// - Reset mid-LOAD after 100 beats: reset_n=0 for 1 cycle.
//   - Required: all outputs 0, cmd_ready=1, no write strobe; a fresh job completes correctly.
// - Spurious ntt_done during LOAD and a repeated done level in COMPUTE.
//   - Required: ignored in LOAD; a single transition to UNLOAD.
// - With NTT_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=100, no done.
//   - Required: err=1 and IDLE after exactly 100 COMPUTE cycles, no mem_read.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT host port: FSM encoding, core geometry and helpers.
package ntt_pkg;
  localparam int NUM_MODULI = 40;
  localparam int MEM_DELAY  = 2;
  localparam int ADDR_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_COMPUTE,
    ST_UNLOAD
  } state_t;

  function automatic int lane_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction
endpackage

// File: rtl/ntt_host_port_if.sv
// Host-port bundle: command, coefficient streams and NTT core memory/control.
interface ntt_host_port_if import ntt_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 257
) ();
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [5:0]               cmd_mod_idx;
  logic [8:0]               cmd_rows;
  logic                     s_valid;
  logic                     s_ready;
  logic [WIDTH-1:0]         s_data;
  logic                     m_valid;
  logic                     m_ready;
  logic [WIDTH-1:0]         m_data;
  logic                     ntt_start;
  logic [5:0]               ntt_mod_idx;
  logic                     ntt_mem_write;
  logic                     ntt_mem_read;
  logic [ADDR_W*SIZE-1:0]   ntt_mem_addr;
  logic [WIDTH*SIZE-1:0]    ntt_din;
  logic [WIDTH*SIZE-1:0]    ntt_dout;
  logic                     ntt_done;
  logic                     busy;
  logic                     err;

  modport master (
    input  cmd_valid, cmd_mod_idx, cmd_rows, s_valid, s_data, m_ready, ntt_dout, ntt_done,
    output cmd_ready, s_ready, m_valid, m_data, ntt_start, ntt_mod_idx, ntt_mem_write,
           ntt_mem_read, ntt_mem_addr, ntt_din, busy, err
  );
  modport slave (
    output cmd_valid, cmd_mod_idx, cmd_rows, s_valid, s_data, m_ready, ntt_dout, ntt_done,
    input  cmd_ready, s_ready, m_valid, m_data, ntt_start, ntt_mod_idx, ntt_mem_write,
           ntt_mem_read, ntt_mem_addr, ntt_din, busy, err
  );
endinterface

// File: rtl/ntt_row_buffer.sv
// SIZE x WIDTH row register: lane-indexed write/read plus full-row load/read.
module ntt_row_buffer #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 257,
  parameter int LW    = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_wr_en,
  input  logic [LW-1:0]         i_wr_lane,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_ld_en,
  input  logic [WIDTH*SIZE-1:0] i_ld_row,
  input  logic [LW-1:0]         i_rd_lane,
  output logic [WIDTH-1:0]      o_rd_data,
  output logic [WIDTH*SIZE-1:0] o_row
);
  logic [SIZE-1:0][WIDTH-1:0] r_lanes;

  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                  r_lanes[g] <= '0;
      else if (i_ld_en)                              r_lanes[g] <= i_ld_row[g*WIDTH +: WIDTH];
      else if (i_wr_en && i_wr_lane == LW'(g))       r_lanes[g] <= i_wr_data;
    end
  end

  assign o_row     = r_lanes;
  assign o_rd_data = r_lanes[i_rd_lane];
endmodule

// File: rtl/ntt_host_port.sv
// Host initiator for the NTT core: packs stream into rows, starts the core, unloads rows.
// Optional compute watchdog enabled by defining NTT_HOST_TIMEOUT_EN.
module ntt_host_port import ntt_pkg::*; #(
  parameter int WIDTH          = 32,
  parameter int SIZE           = 257,
  parameter int ROWS           = 256,
  parameter int MEM_RD_LATENCY = MEM_DELAY,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic           clk,
  input  logic           reset_n,
  ntt_host_port_if.master bus
);
  localparam int LW = lane_w(SIZE);

  if (ROWS < 1 || ROWS > (1 << ADDR_W) || MEM_RD_LATENCY < 1 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("ntt_host_port: parameter out of range");
  end

  state_t                  r_state;
  logic [5:0]              r_mod_idx;
  logic [8:0]              r_rows, r_row;
  logic [LW-1:0]           r_lane;
  logic                    r_err, r_wr, r_mvalid, r_done_q;
  logic [MEM_RD_LATENCY:0] r_vld_pipe;   // [0] is the read strobe, [L] marks dout valid
`ifdef NTT_HOST_TIMEOUT_EN
  logic [15:0]             r_wdog;
`endif

  logic                    w_s_ready, w_s_fire, w_m_fire, w_done_rise;
  logic                    w_last_lane, w_last_row, w_cmd_bad;
  logic [WIDTH-1:0]        w_rd_data;
  logic [WIDTH*SIZE-1:0]   w_row;

  assign w_s_ready   = (r_state == ST_LOAD) && !r_wr;
  assign w_s_fire    = w_s_ready && bus.s_valid;
  assign w_m_fire    = r_mvalid && bus.m_ready;
  assign w_done_rise = bus.ntt_done && !r_done_q;
  assign w_last_lane = (r_lane == LW'(SIZE - 1));
  assign w_last_row  = (r_row + 9'd1 == r_rows);
  assign w_cmd_bad   = (int'(bus.cmd_mod_idx) >= NUM_MODULI) || (bus.cmd_rows == 9'd0) ||
                       (int'(bus.cmd_rows) > ROWS);

  ntt_row_buffer #(.WIDTH(WIDTH), .SIZE(SIZE), .LW(LW)) u_row_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr_en   (w_s_fire),
    .i_wr_lane (r_lane),
    .i_wr_data (bus.s_data),
    .i_ld_en   (r_vld_pipe[MEM_RD_LATENCY]),
    .i_ld_row  (bus.ntt_dout),
    .i_rd_lane (r_lane),
    .o_rd_data (w_rd_data),
    .o_row     (w_row)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_mod_idx  <= '0;
      r_rows     <= '0;
      r_row      <= '0;
      r_lane     <= '0;
      r_err      <= 1'b0;
      r_wr       <= 1'b0;
      r_mvalid   <= 1'b0;
      r_done_q   <= 1'b0;
      r_vld_pipe <= '0;
`ifdef NTT_HOST_TIMEOUT_EN
      r_wdog     <= '0;
`endif
    end else begin
      r_done_q   <= bus.ntt_done;
      r_vld_pipe <= {r_vld_pipe[MEM_RD_LATENCY-1:0], 1'b0};
      case (r_state)
        ST_IDLE: if (bus.cmd_valid) begin
          if (w_cmd_bad) r_err <= 1'b1;
          else begin
            r_err     <= 1'b0;
            r_mod_idx <= bus.cmd_mod_idx;
            r_rows    <= bus.cmd_rows;
            r_row     <= '0;
            r_lane    <= '0;
            r_state   <= ST_LOAD;
          end
        end
        ST_LOAD: if (r_wr) begin
          r_wr <= 1'b0;
          if (w_last_row) begin
            r_row   <= '0;
            r_state <= ST_START;
          end else r_row <= r_row + 9'd1;
        end else if (w_s_fire) begin
          if (w_last_lane) begin
            r_lane <= '0;
            r_wr   <= 1'b1;
          end else r_lane <= r_lane + 1'b1;
        end
        ST_START: begin
          r_state <= ST_COMPUTE;
`ifdef NTT_HOST_TIMEOUT_EN
          r_wdog  <= '0;
`endif
        end
        ST_COMPUTE: if (w_done_rise) begin
          r_state       <= ST_UNLOAD;
          r_vld_pipe[0] <= 1'b1;
        end
`ifdef NTT_HOST_TIMEOUT_EN
        else if (r_wdog == 16'(TIMEOUT_CYCLES - 1)) begin
          r_err   <= 1'b1;
          r_state <= ST_IDLE;
        end else r_wdog <= r_wdog + 16'd1;
`endif
        ST_UNLOAD: if (r_vld_pipe[MEM_RD_LATENCY]) begin
          r_mvalid <= 1'b1;
          r_lane   <= '0;
        end else if (w_m_fire) begin
          if (w_last_lane) begin
            r_mvalid <= 1'b0;
            r_lane   <= '0;
            if (w_last_row) begin
              r_row   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_row         <= r_row + 9'd1;
              r_vld_pipe[0] <= 1'b1;
            end
          end else r_lane <= r_lane + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready     = (r_state == ST_IDLE);
  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.err           = r_err;
  assign bus.s_ready       = w_s_ready;
  assign bus.m_valid       = r_mvalid;
  assign bus.m_data        = w_rd_data;
  assign bus.ntt_start     = (r_state == ST_START);
  assign bus.ntt_mod_idx   = r_mod_idx;
  assign bus.ntt_mem_write = r_wr;
  assign bus.ntt_mem_read  = r_vld_pipe[0];
  assign bus.ntt_mem_addr  = (r_wr || r_vld_pipe[0]) ? {SIZE{r_row[ADDR_W-1:0]}} : '0;
  assign bus.ntt_din       = w_row;
endmodule

// File: tb/tb_ntt_host_port.sv
// Directed bench for ntt_host_port with a small core/memory model (SIZE reduced to 5 lanes).
module tb_ntt_host_port;
  import ntt_pkg::*;
  localparam int W = 32, S = 5, R = 256, L = 2, TO = 100;

  logic clk = 1'b0, reset_n = 1'b0;
  int   n_vec = 0, n_bad = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ntt_host_port_if #(.WIDTH(W), .SIZE(S)) bus ();
  ntt_host_port #(.WIDTH(W), .SIZE(S), .ROWS(R), .MEM_RD_LATENCY(L), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));

  logic [W-1:0] mem [0:R-1][0:S-1];
  logic [W-1:0] outq[$];
  logic [5:0]   cur_mod = '0;
  logic         bp = 1'b0;
  int n_wr, n_rd, n_start, wr_next, rd_next, bad_order, bad_addr, bad_mutex, bad_hold, stall;
  int wr_cyc, acc_cyc, first_rd_cyc, first_mv_cyc, start_cyc, idle_cyc;
  logic p0 = 0, p1 = 0, p2 = 0, stalled = 0;
  logic [7:0] a0 = 0, a1 = 0, a2 = 0;
  logic [W-1:0] held = '0;

  // core model: returned rows are the written rows scrambled with the modulus index
  function automatic logic [W-1:0] xform(input logic [W-1:0] v);
    return v ^ 32'hC0DE_0000 ^ {26'd0, cur_mod};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] a;
    a = bus.ntt_mem_addr[7:0];
    if (bus.ntt_mem_write && bus.ntt_mem_read) bad_mutex++;
    for (int k = 0; k < S; k++)
      if (bus.ntt_mem_addr[k*8 +: 8] != ((bus.ntt_mem_write || bus.ntt_mem_read) ? a : 8'd0)) bad_addr++;
    if (bus.ntt_mem_write) begin
      n_wr++; wr_cyc = cyc;
      if (a != 8'(wr_next)) bad_order++;
      wr_next++;
      for (int k = 0; k < S; k++) mem[a][k] = bus.ntt_din[k*W +: W];
    end
    if (bus.ntt_mem_read) begin
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      n_rd++;
      if (a != 8'(rd_next)) bad_order++;
      rd_next++;
    end
    if (bus.ntt_start) begin n_start++; start_cyc = cyc; end
    if (bus.m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
    if (stalled && (!bus.m_valid || bus.m_data != held)) bad_hold++;
    stalled = bus.m_valid && !bus.m_ready;
    held    = bus.m_data;
    if (bus.m_valid && bus.m_ready) outq.push_back(bus.m_data);
    p2 = p1; a2 = a1; p1 = p0; a1 = a0; p0 = bus.ntt_mem_read; a0 = a;
    for (int k = 0; k < S; k++)
      bus.ntt_dout[k*W +: W] = p2 ? xform(mem[a2][k]) : (32'hBAD0_0000 | k);
  end

  task automatic clr_mon();
    n_wr = 0; n_rd = 0; n_start = 0; wr_next = 0; rd_next = 0; bad_order = 0; bad_addr = 0;
    bad_mutex = 0; bad_hold = 0; stall = 0; first_rd_cyc = -1; first_mv_cyc = -1;
    outq.delete();
  endtask

  task automatic send_cmd(input logic [5:0] m, input logic [8:0] r);
    bus.cmd_valid = 1'b1; bus.cmd_mod_idx = m; bus.cmd_rows = r;
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic stream(input int n, input int base);
    for (int j = 0; j < n; j++) begin
      logic f;
      int   g;
      f = 1'b0; g = 0;
      bus.s_valid = 1'b1; bus.s_data = W'(base + j);
      while (!f && g < 50) begin
        @(negedge clk); f = bus.s_ready; if (f) acc_cyc = cyc;
        @(posedge clk); #1; g++;
      end
      if (!f) stall++;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_start();
    int g = 0;
    while (n_start == 0 && g < 3000) begin @(posedge clk); #1; g++; end
    chk("start_seen", n_start, 1);
  endtask

  task automatic pulse_done(input int dly);
    wait_start();
    repeat (dly) @(posedge clk);
    #1 bus.ntt_done = 1'b1;
    @(posedge clk); #1 bus.ntt_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (bus.busy && g < 20000) begin
      @(posedge clk); #1;
      if (bp) bus.m_ready = ~bus.m_ready;
      g++;
    end
    chk(tag, bus.busy, 0);
  endtask

  task automatic check_out(input string tag, input int n, input int base);
    int nb = 0;
    chk({tag, "_cnt"}, outq.size(), n);
    for (int j = 0; j < outq.size() && j < n; j++)
      if (outq[j] !== xform(W'(base + j))) nb++;
    chk({tag, "_data"}, nb, 0);
  endtask

  task automatic check_hyg(input string tag);
    chk({tag, "_order"}, bad_order, 0);
    chk({tag, "_addr"},  bad_addr, 0);
    chk({tag, "_mutex"}, bad_mutex, 0);
    chk({tag, "_hold"},  bad_hold, 0);
    chk({tag, "_stall"}, stall, 0);
  endtask

  initial begin
    bus.cmd_valid = 0; bus.cmd_mod_idx = 0; bus.cmd_rows = 0; bus.s_valid = 0; bus.s_data = 0;
    bus.m_ready = 1; bus.ntt_done = 0;
    clr_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_strobes", {bus.ntt_start, bus.ntt_mem_write, bus.ntt_mem_read, bus.s_ready, bus.m_valid}, 0);
    chk("rst_din_nz", |bus.ntt_din, 0);
    reset_n = 1'b1;

    // single row, lane k = k
    cur_mod = 0; clr_mon();
    send_cmd(0, 1);
    chk("single_busy", bus.busy, 1);
    chk("single_cmd_ready", bus.cmd_ready, 0);
    stream(S, 0);
    pulse_done(50);
    wait_idle("single_idle");
    chk("single_wr_lat", wr_cyc - acc_cyc, 1);
    chk("single_n_wr", n_wr, 1);
    chk("single_n_start", n_start, 1);
    chk("single_n_rd", n_rd, 1);
    chk("single_rd_lat", first_mv_cyc - first_rd_cyc, L + 1);
    for (int k = 0; k < S; k++) chk($sformatf("single_lane%0d", k), mem[0][k], k);
    for (int k = 0; k < S; k++) chk($sformatf("single_out%0d", k), outq[k], xform(W'(k)));
    check_hyg("single");

    // illegal commands, then a legal one clears err
    clr_mon();
    send_cmd(40, 1);
    chk("ill_mod_err", bus.err, 1);
    chk("ill_mod_busy", bus.busy, 0);
    send_cmd(0, 0);
    chk("ill_rows0_err", bus.err, 1);
    send_cmd(1, 257);
    chk("ill_rows257_err", bus.err, 1);
    chk("ill_busy", bus.busy, 0);
    repeat (5) @(posedge clk);
    #1 chk("ill_activity", n_start + n_wr + n_rd, 0);
    cur_mod = 5;
    send_cmd(5, 1);
    chk("legal_err_clr", bus.err, 0);
    stream(S, 500);
    pulse_done(3);
    wait_idle("legal_idle");
    check_out("legal", S, 500);

    // spurious done in LOAD, done level held in COMPUTE
    cur_mod = 9; clr_mon();
    send_cmd(9, 2);
    stream(3, 700);
    bus.ntt_done = 1'b1;
    @(posedge clk); #1 bus.ntt_done = 1'b0;
    chk("spur_s_ready", bus.s_ready, 1);
    chk("spur_busy", bus.busy, 1);
    stream(2 * S - 3, 703);
    wait_start();
    repeat (5) @(posedge clk);
    #1 bus.ntt_done = 1'b1;
    repeat (20) @(posedge clk);
    #1 bus.ntt_done = 1'b0;
    wait_idle("spur_idle");
    chk("spur_n_start", n_start, 1);
    chk("spur_n_rd", n_rd, 2);
    check_out("spur", 2 * S, 700);
    check_hyg("spur");

    // full 256-row job with m_ready toggling
    cur_mod = 7; clr_mon();
    send_cmd(7, 9'd256);
    stream(R * S, 1000);
    pulse_done(10);
    chk("full_mod_idx", bus.ntt_mod_idx, 7);
    bp = 1'b1;
    wait_idle("full_idle");
    bp = 1'b0; bus.m_ready = 1'b1;
    chk("full_n_wr", n_wr, R);
    chk("full_n_rd", n_rd, R);
    check_out("full", R * S, 1000);
    check_hyg("full");

    // async reset after 100 beats of a 30-row load
    cur_mod = 2; clr_mon();
    send_cmd(2, 30);
    stream(100, 3000);
    reset_n = 1'b0;
    #1;
    chk("mrst_cmd_ready", bus.cmd_ready, 1);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_strobes", {bus.ntt_start, bus.ntt_mem_write, bus.ntt_mem_read, bus.s_ready, bus.m_valid}, 0);
    chk("mrst_addr_nz", |bus.ntt_mem_addr, 0);
    chk("mrst_din_nz", |bus.ntt_din, 0);
    chk("mrst_mod_idx", bus.ntt_mod_idx, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mrst_n_wr", n_wr, 19);
    chk("mrst_n_start", n_start, 0);
    clr_mon();
    send_cmd(2, 3);
    stream(3 * S, 4000);
    pulse_done(5);
    wait_idle("fresh_idle");
    chk("fresh_n_wr", n_wr, 3);
    check_out("fresh", 3 * S, 4000);
    check_hyg("fresh");

`ifdef NTT_HOST_TIMEOUT_EN
    // watchdog: no done, COMPUTE lasts exactly TO cycles
    begin
      int g;
      g = 0;
      cur_mod = 1; clr_mon();
      send_cmd(1, 1);
      stream(S, 0);
      wait_start();
      while (bus.busy && g < 500) begin @(negedge clk); g++; end
      idle_cyc = cyc;
      chk("to_len", idle_cyc - start_cyc, TO + 1);
      chk("to_err", bus.err, 1);
      chk("to_n_rd", n_rd, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
